dsi_host_top_sys: RTL and testbench
===================================

Name:
dsi_host_top_sys

Overview:
- CPU-side system hub of the DSI host.
- Takes the soft-core's simple memory bus and decodes each access to one of three targets: the on-board RAM via a single-beat AXI4-Lite master, the debug port register, or unmapped space.
- DDR controller, DPHY serializer and HDMI capture live in sibling blocks and are outside this block.

Parameters:
- RAM_ADDR_W, 18: byte-address width of the RAM window 0x0000_0000..2^RAM_ADDR_W-1 (256 KB, 65536 words).
- DEBUG_ADDR, 32'h1000_0000: word address of the write-only debug port.

Ports:
- clk_in  in  1  system clock; one clock for the whole block.
- rst_n_in  in  1  synchronous, active-low reset.
- bus_addr  in  32  byte address, held while a request is pending.
- bus_write  in  1  write request, held until bus_ready.
- bus_read  in  1  read request, held until bus_ready.
- bus_writedata  in  32  write data.
- bus_byteen  in  4  byte enables for writes.
- bus_readdata  out  32  read data, valid when bus_ready=1.
- bus_ready  out  1  one-cycle completion pulse.
- debug_valid  out  1  one-cycle pulse on a debug-port write.
- debug_data  out  32  last value written to DEBUG_ADDR.
- m_axi_awaddr  out  32, m_axi_awvalid out 1, m_axi_awready in 1: AW channel.
- m_axi_wdata  out  32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1: W channel.
- m_axi_bresp  in  2, m_axi_bvalid in 1, m_axi_bready out 1: B channel.
- m_axi_araddr  out  32, m_axi_arvalid out 1, m_axi_arready in 1: AR channel.
- m_axi_rdata  in  32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1: R channel.

Behaviour:
- Reset (rst_n_in=0 at a clk_in edge) forces:
  - FSM to IDLE;
  - all AXI valid/ready outputs, bus_ready and debug_valid to 0;
  - bus_readdata, debug_data, m_axi_awaddr and m_axi_araddr to 0.
- Reset mid-transaction abandons the transaction with no completion pulse. Handshakes already in flight are not honoured.
- FSM states: IDLE, DBG, AXI_WR, AXI_B, AXI_AR, AXI_R, DONE.
- Requests are sampled only in IDLE. If bus_write and bus_read are both high, the write wins.
- Decode in IDLE:
  - bus_addr < 2^RAM_ADDR_W: RAM (AXI).
  - bus_addr == DEBUG_ADDR: debug port.
  - anything else: unmapped.
- Debug write:
  - IDLE -> DONE. debug_data <= bus_writedata and debug_valid=1 for exactly that one cycle.
  - bus_ready comes 1 cycle after sampling.
  - A read of DEBUG_ADDR returns 0.
- Unmapped access:
  - IDLE -> DONE. Writes are dropped; reads return bus_readdata=0.
  - No AXI activity.
- RAM write:
  - Entering AXI_WR: m_axi_awaddr = {bus_addr[31:2],2'b00}, wdata = bus_writedata, wstrb = bus_byteen.
  - awvalid and wvalid are both asserted in the same cycle. Each is dropped independently on its own handshake (valid & ready at an edge).
  - Once both handshakes have completed -> AXI_B with bready=1. On bvalid -> DONE.
  - Exactly one AW and one W handshake per access.
- RAM read:
  - AXI_AR: araddr = word-aligned bus_addr, arvalid held until arready.
  - Then AXI_R with rready=1. On rvalid, bus_readdata <= rdata -> DONE.
- AXI valids are never withdrawn before their handshake. Addresses and data are stable while valid is high.
- Any response delay (0..N cycles) on awready/wready/bvalid/arready/rvalid must be tolerated.
- bresp/rresp are ignored; the access completes normally and read data is passed through.
- DONE:
  - bus_ready=1 for exactly one cycle, then IDLE.
  - The still-asserted request in the DONE cycle is not re-sampled, so one request gives one transaction.
- bus_readdata holds its value until the next read completes.
- No accesses are pipelined: at most one outstanding AXI transaction.

Test Plan:
- Debug write: bus_write, addr 0x1000_0000, data 0xDEADBEEF -> debug_valid high exactly 1 cycle; debug_data=0xDEADBEEF; bus_ready 1 cycle later; no AXI valids.
- RAM write with skew: addr 0x0000_0100, data 0x12345678, byteen 0xF; wready immediate, awready 5 cycles late, bvalid 3 cycles later -> one AW (awaddr 0x100) and one W (wstrb 0xF); bus_ready a single pulse after bvalid.
- RAM readback: read 0x0000_0100 from a slave model returning 0x12345678 after a random 0..10 cycle delay -> bus_readdata=0x12345678 with a one-cycle bus_ready; repeat for 200 random word addresses below 0x4_0000 against a memory model, all matching.
- Unmapped: read 0x2000_0000 -> bus_readdata=0, bus_ready 1 cycle after sampling, no AXI valids; a write to 0x0004_0000 is dropped with the same response.
- Simultaneous bus_write and bus_read to 0x0000_0010 -> only an AW/W transaction is issued.
- Reset mid-read: assert rst_n_in=0 while arvalid=1 -> next cycle all outputs at reset values; after release, a fresh read completes normally.

Source files
------------

// File: rtl/dsi_host_top_sys.sv
// CPU-side system hub: decodes soft-core bus accesses to RAM (single-beat AXI4-Lite), debug port or unmapped space.
// One access at a time; bus_ready pulses for one cycle when the access retires.
module dsi_host_top_sys #(
   parameter int          RAM_ADDR_W = 18,
   parameter logic [31:0] DEBUG_ADDR = 32'h1000_0000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] bus_addr,
   input  logic        bus_write,
   input  logic        bus_read,
   input  logic [31:0] bus_writedata,
   input  logic [3:0]  bus_byteen,
   output logic [31:0] bus_readdata,
   output logic        bus_ready,
   output logic        debug_valid,
   output logic [31:0] debug_data,
   output logic [31:0] m_axi_awaddr,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   typedef enum logic [2:0] {IDLE, DBG, AXI_WR, AXI_B, AXI_AR, AXI_R, DONE} state_t;

   state_t state, state_nxt;
   logic   ram_hit, dbg_hit;
   logic   resp_unused;

   // Responses are not reported back to the CPU bus.
   assign resp_unused = ^{m_axi_bresp, m_axi_rresp};

   assign ram_hit = (bus_addr[31:RAM_ADDR_W] == '0);
   assign dbg_hit = (bus_addr == DEBUG_ADDR);

   assign bus_ready    = (state == DONE);
   assign m_axi_bready = (state == AXI_B);
   assign m_axi_rready = (state == AXI_R);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus_write)     state_nxt = ram_hit ? AXI_WR : DONE;
            else if (bus_read) state_nxt = ram_hit ? AXI_AR : DONE;
         end
         DBG:    state_nxt = DONE;
         AXI_WR: begin
            // Each channel is finished once its valid has dropped or handshakes now.
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready))
               state_nxt = AXI_B;
         end
         AXI_B:  if (m_axi_bvalid)  state_nxt = DONE;
         AXI_AR: if (m_axi_arready) state_nxt = AXI_R;
         AXI_R:  if (m_axi_rvalid)  state_nxt = DONE;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         bus_readdata  <= '0;
         debug_valid   <= 1'b0;
         debug_data    <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
      end else begin
         debug_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus_write) begin
                  if (ram_hit) begin
                     m_axi_awaddr  <= {bus_addr[31:2], 2'b00};
                     m_axi_wdata   <= bus_writedata;
                     m_axi_wstrb   <= bus_byteen;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                  end else if (dbg_hit) begin
                     debug_data  <= bus_writedata;
                     debug_valid <= 1'b1;
                  end
               end else if (bus_read) begin
                  if (ram_hit) begin
                     m_axi_araddr  <= {bus_addr[31:2], 2'b00};
                     m_axi_arvalid <= 1'b1;
                  end else begin
                     bus_readdata <= '0;
                  end
               end
            end
            AXI_WR: begin
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            end
            AXI_AR: if (m_axi_arready) m_axi_arvalid <= 1'b0;
            AXI_R:  if (m_axi_rvalid)  bus_readdata  <= m_axi_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsi_host_top_sys.sv
// Bench for dsi_host_top_sys: randomized AXI slave delays, memory reference model, directed boundary cases.
module tb_dsi_host_top_sys;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [31:0] bus_addr, bus_writedata, bus_readdata, debug_data;
   logic        bus_write, bus_read, bus_ready, debug_valid;
   logic [3:0]  bus_byteen;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   dsi_host_top_sys dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .bus_addr(bus_addr), .bus_write(bus_write), .bus_read(bus_read),
      .bus_writedata(bus_writedata), .bus_byteen(bus_byteen),
      .bus_readdata(bus_readdata), .bus_ready(bus_ready),
      .debug_valid(debug_valid), .debug_data(debug_data),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- AXI slave model ----------------
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   int aw_hs = 0, w_hs = 0, ar_hs = 0;
   logic [31:0] slv_mem [int];
   logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, r_addr = '0;
   logic [3:0]  cap_wstrb = '0;
   int ready_cnt = 0, dbgv_cnt = 0, axiv_cnt = 0;

   always @(posedge clk_in) begin
      if (!rst_n_in) begin
         aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            aw_got = 1'b1; cap_awaddr = m_axi_awaddr; aw_hs++;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            w_got = 1'b1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; w_hs++;
         end
         if (m_axi_bvalid && m_axi_bready) b_pend = 1'b0;
         if (aw_got && w_got) begin
            logic [31:0] v;
            v = slv_mem.exists(int'(cap_awaddr >> 2)) ? slv_mem[int'(cap_awaddr >> 2)] : 32'h0;
            for (int b = 0; b < 4; b++)
               if (cap_wstrb[b]) v[8*b +: 8] = cap_wdata[8*b +: 8];
            slv_mem[int'(cap_awaddr >> 2)] = v;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
         end
         if (m_axi_rvalid && m_axi_rready) r_pend = 1'b0;
         if (m_axi_arvalid && m_axi_arready) begin
            r_addr = m_axi_araddr; r_pend = 1'b1; ar_hs++;
         end
      end
   end

   always @(negedge clk_in) begin
      if (bus_ready) ready_cnt++;
      if (debug_valid) dbgv_cnt++;
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) axiv_cnt++;
      if (!rst_n_in) begin
         m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
         m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
         aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      end else begin
         if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_dly); aw_wait++; end
         else begin m_axi_awready = 1'b0; aw_wait = 0; end
         if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_dly); w_wait++; end
         else begin m_axi_wready = 1'b0; w_wait = 0; end
         if (b_pend) begin m_axi_bvalid = (b_wait >= b_dly); b_wait++; end
         else begin m_axi_bvalid = 1'b0; b_wait = 0; end
         if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_dly); ar_wait++; end
         else begin m_axi_arready = 1'b0; ar_wait = 0; end
         if (r_pend) begin
            m_axi_rvalid = (r_wait >= r_dly); r_wait++;
            m_axi_rdata  = slv_mem.exists(int'(r_addr >> 2)) ? slv_mem[int'(r_addr >> 2)] : 32'h0;
         end else begin
            m_axi_rvalid = 1'b0; r_wait = 0; m_axi_rdata = $urandom;
         end
         m_axi_bresp = 2'($urandom_range(0, 3));
         m_axi_rresp = 2'($urandom_range(0, 3));
      end
   end

   // ---------------- reference memory ----------------
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] ref_rd(input logic [31:0] addr);
      return ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
   endfunction

   task automatic ref_wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] v;
      v = ref_rd(addr);
      for (int b = 0; b < 4; b++)
         if (be[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(addr >> 2)] = v;
   endtask

   task automatic access(input logic [31:0] addr, input logic wr, input logic rd,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rdat, output int lat);
      @(negedge clk_in);
      bus_addr = addr; bus_write = wr; bus_read = rd; bus_writedata = wd; bus_byteen = be;
      lat = 0;
      do begin
         @(negedge clk_in);
         lat++;
      end while (!bus_ready && lat < 200);
      if (!bus_ready) chk("access_timeout", 32'(bus_ready), 32'd1);
      rdat = bus_readdata;
      bus_write = 1'b0; bus_read = 1'b0;
      @(negedge clk_in);
      chk("ready_one_cycle", 32'(bus_ready), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, a, d;
      logic [3:0]  be;
      int lat, r0, d0, v0, aw0, w0, ar0, nwr;

      rst_n_in = 1'b0;
      bus_addr = '0; bus_write = 1'b0; bus_read = 1'b0; bus_writedata = '0; bus_byteen = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_ready", 32'(bus_ready), 32'd0);
      chk("rst_dbg_valid", 32'(debug_valid), 32'd0);
      chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
      chk("rst_readdata", bus_readdata, 32'h0);
      chk("rst_dbg_data", debug_data, 32'h0);
      chk("rst_awaddr", m_axi_awaddr, 32'h0);
      chk("rst_araddr", m_axi_araddr, 32'h0);
      rst_n_in = 1'b1;

      // debug write
      r0 = ready_cnt; d0 = dbgv_cnt; v0 = axiv_cnt;
      access(32'h1000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, rd, lat);
      chk("dbg_latency", lat, 1);
      chk("dbg_data", debug_data, 32'hDEAD_BEEF);
      chk("dbg_valid_cycles", dbgv_cnt - d0, 1);
      chk("dbg_ready_cycles", ready_cnt - r0, 1);
      chk("dbg_no_axi", axiv_cnt - v0, 0);

      // RAM write with AW lagging W
      aw_dly = 5; w_dly = 0; b_dly = 3;
      aw0 = aw_hs; w0 = w_hs; r0 = ready_cnt;
      access(32'h0000_0100, 1'b1, 1'b0, 32'h1234_5678, 4'hF, rd, lat);
      ref_wr(32'h100, 32'h1234_5678, 4'hF);
      chk("skew_aw_count", aw_hs - aw0, 1);
      chk("skew_w_count", w_hs - w0, 1);
      chk("skew_awaddr", cap_awaddr, 32'h100);
      chk("skew_wstrb", 32'(cap_wstrb), 32'hF);
      chk("skew_wdata", cap_wdata, 32'h1234_5678);
      chk("skew_ready_cycles", ready_cnt - r0, 1);

      // readback
      ar_dly = $urandom_range(0, 10); r_dly = $urandom_range(0, 10);
      r0 = ready_cnt;
      access(32'h0000_0100, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      chk("readback", rd, 32'h1234_5678);
      chk("readback_ready_cycles", ready_cnt - r0, 1);

      // unmapped read/write and debug read
      v0 = axiv_cnt;
      access(32'h2000_0000, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      chk("unmap_rd_data", rd, 32'h0);
      chk("unmap_rd_latency", lat, 1);
      chk("unmap_rd_no_axi", axiv_cnt - v0, 0);
      aw0 = aw_hs;
      access(32'h0004_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF, rd, lat);
      chk("unmap_wr_latency", lat, 1);
      chk("unmap_wr_no_aw", aw_hs - aw0, 0);
      chk("unmap_wr_no_axi", axiv_cnt - v0, 0);
      access(32'h0000_0100, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      access(32'h1000_0000, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      chk("dbg_read_zero", rd, 32'h0);
      chk("dbg_read_keeps_data", debug_data, 32'hDEAD_BEEF);

      // write wins over read
      aw0 = aw_hs; ar0 = ar_hs;
      access(32'h0000_0010, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF, rd, lat);
      ref_wr(32'h10, 32'hCAFE_F00D, 4'hF);
      chk("both_aw_count", aw_hs - aw0, 1);
      chk("both_ar_count", ar_hs - ar0, 0);
      access(32'h0000_0010, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      chk("both_readback", rd, 32'hCAFE_F00D);

      // randomized traffic against the reference memory
      aw0 = aw_hs; w0 = w_hs; nwr = 0;
      for (int i = 0; i < 200; i++) begin
         aw_dly = $urandom_range(0, 10); w_dly = $urandom_range(0, 10); b_dly = $urandom_range(0, 10);
         ar_dly = $urandom_range(0, 10); r_dly = $urandom_range(0, 10);
         if ($urandom_range(0, 1) == 1) a = {14'h0, 16'($urandom_range(0, 65535)), 2'b00};
         else                           a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; be = 4'($urandom_range(0, 15));
            access(a, 1'b1, 1'b0, d, be, rd, lat);
            ref_wr(a, d, be);
            nwr++;
         end else begin
            access(a, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
            chk("rand_read", rd, ref_rd(a));
         end
      end
      chk("rand_aw_total", aw_hs - aw0, nwr);
      chk("rand_w_total", w_hs - w0, nwr);

      // reset while a read address is pending
      ar_dly = 30; r_dly = 0;
      @(negedge clk_in);
      bus_addr = 32'h0000_0100; bus_read = 1'b1;
      for (int i = 0; i < 10 && !m_axi_arvalid; i++) @(negedge clk_in);
      chk("mid_rst_arvalid_seen", 32'(m_axi_arvalid), 32'd1);
      rst_n_in = 1'b0; bus_read = 1'b0;
      @(negedge clk_in);
      chk("mid_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
      chk("mid_rst_ready", 32'(bus_ready), 32'd0);
      chk("mid_rst_readdata", bus_readdata, 32'h0);
      chk("mid_rst_araddr", m_axi_araddr, 32'h0);
      chk("mid_rst_dbg_data", debug_data, 32'h0);
      rst_n_in = 1'b1;
      ar_dly = 2; r_dly = 3;
      r0 = ready_cnt;
      access(32'h0000_0100, 1'b0, 1'b1, 32'h0, 4'h0, rd, lat);
      chk("post_rst_read", rd, ref_rd(32'h100));
      chk("post_rst_ready_cycles", ready_cnt - r0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
